// File: rtl/sdram_port_scheduler_if.sv
// Handshake/bus bundle between the port FIFOs, the command sequencer and the scheduler.
// Pure wiring, no latency of its own.
// No backpressure here; the scheduler's request level is held until the sequencer signals done.
interface sdram_port_scheduler_if #(
   parameter int ASIZE = 22,
   parameter int LSIZE = 9
);
   logic [4*ASIZE-1:0] START_ADDR;
   logic [4*ASIZE-1:0] MAX_ADDR;
   logic [4*LSIZE-1:0] LENGTH;
   logic [3:0]         LOAD;
   logic [4*LSIZE-1:0] USEDW;
   logic               SEQ_IDLE;
   logic               WR_DONE;
   logic               RD_DONE;
   logic               REQ_WR;
   logic               REQ_RD;
   logic [ASIZE-1:0]   REQ_ADDR;
   logic [LSIZE-1:0]   REQ_LENGTH;
   logic [1:0]         WR_MASK;
   logic [1:0]         RD_MASK;
   logic [1:0]         GRANT_ID;

   // scheduler side
   modport slave (
      input  START_ADDR, MAX_ADDR, LENGTH, LOAD, USEDW, SEQ_IDLE, WR_DONE, RD_DONE,
      output REQ_WR, REQ_RD, REQ_ADDR, REQ_LENGTH, WR_MASK, RD_MASK, GRANT_ID
   );

   // FIFO/sequencer side
   modport master (
      output START_ADDR, MAX_ADDR, LENGTH, LOAD, USEDW, SEQ_IDLE, WR_DONE, RD_DONE,
      input  REQ_WR, REQ_RD, REQ_ADDR, REQ_LENGTH, WR_MASK, RD_MASK, GRANT_ID
   );
endinterface

// File: rtl/sdram_port_scheduler.sv
// Four-port SDRAM burst scheduler (2 write, 2 read ports) with per-port wrap-around address walk.
// Latency: grant registered 1 cycle after eligibility is sampled; done -> request low next cycle, 1-cycle gap.
// Backpressure: request level held through the burst until WR_DONE/RD_DONE; LOAD on any port blocks new grants.
// Optional: define SCHED_ROUND_ROBIN_EN for rotating priority; default is fixed priority 0 > 1 > 2 > 3.
module sdram_port_scheduler #(
   parameter int ASIZE      = 22,
   parameter int LSIZE      = 9,
   parameter int DEF_LENGTH = 256
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   sdram_port_scheduler_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   // per-port registers
   logic [ASIZE-1:0] r_addr [4];
   logic [ASIZE-1:0] r_max  [4];
   logic [LSIZE-1:0] r_len  [4];

   // registered outputs and their next values
   logic             r_req_wr,   w_req_wr_nxt;
   logic             r_req_rd,   w_req_rd_nxt;
   logic [ASIZE-1:0] r_req_addr, w_req_addr_nxt;
   logic [LSIZE-1:0] r_req_len,  w_req_len_nxt;
   logic [1:0]       r_wr_mask,  w_wr_mask_nxt;
   logic [1:0]       r_rd_mask,  w_rd_mask_nxt;
   logic [1:0]       r_grant_id, w_grant_id_nxt;

   logic [3:0]       w_elig;
   logic [ASIZE:0]   w_sum      [4];
   logic [ASIZE-1:0] w_adv_addr [4];
   logic             w_done;
   logic             w_win_vld;
   logic [1:0]       w_win_id;

   // Only a done matching the running direction ends the burst; the other direction's pulse is noise.
   assign w_done = (r_state == ST_BUSY) &&
                   ((bus.WR_DONE && r_req_wr) || (bus.RD_DONE && r_req_rd));

   // Write ports need a full burst buffered; read ports need room for a full burst. len 0 parks a port.
   always_comb begin
      w_elig = 4'b0000;
      for (int p = 0; p < 4; p++) begin
         if (r_len[p] != '0) begin
            if (p < 2) w_elig[p] = (bus.USEDW[p*LSIZE +: LSIZE] >= r_len[p]);
            else       w_elig[p] = (bus.USEDW[p*LSIZE +: LSIZE] <  r_len[p]);
         end
      end
   end

   // Next burst address per port: step by len, or wrap to the live start address once max is reached.
   always_comb begin
      for (int p = 0; p < 4; p++) begin
         w_sum[p]      = {1'b0, r_addr[p]} + {{(ASIZE+1-LSIZE){1'b0}}, r_len[p]};
         w_adv_addr[p] = (w_sum[p] < {1'b0, r_max[p]}) ? w_sum[p][ASIZE-1:0]
                                                       : bus.START_ADDR[p*ASIZE +: ASIZE];
      end
   end

`ifdef SCHED_ROUND_ROBIN_EN
   // Rotating priority: search begins just after the last granted port (port 0 first after reset).
   always_comb begin
      logic [1:0] v_idx;
      v_idx     = 2'd0;
      w_win_vld = 1'b0;
      w_win_id  = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         v_idx = r_grant_id + 2'(k) + 2'd1;
         if (w_elig[v_idx]) begin
            w_win_vld = 1'b1;
            w_win_id  = v_idx;
         end
      end
   end
`else
   // Fixed priority: lowest port index wins, so writes always beat reads.
   always_comb begin
      w_win_vld = 1'b0;
      w_win_id  = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (w_elig[k]) begin
            w_win_vld = 1'b1;
            w_win_id  = 2'(k);
         end
      end
   end
`endif

   // Next-state and next-output decode; outputs hold their value unless a grant or done changes them.
   always_comb begin
      w_state_nxt    = r_state;
      w_req_wr_nxt   = r_req_wr;
      w_req_rd_nxt   = r_req_rd;
      w_req_addr_nxt = r_req_addr;
      w_req_len_nxt  = r_req_len;
      w_wr_mask_nxt  = r_wr_mask;
      w_rd_mask_nxt  = r_rd_mask;
      w_grant_id_nxt = r_grant_id;
      case (r_state)
         ST_IDLE: begin
            if (bus.SEQ_IDLE && (bus.LOAD == 4'b0000) && w_win_vld) begin
               w_state_nxt    = ST_BUSY;
               w_req_wr_nxt   = ~w_win_id[1];
               w_req_rd_nxt   =  w_win_id[1];
               w_req_addr_nxt = r_addr[w_win_id];
               w_req_len_nxt  = r_len[w_win_id];
               w_wr_mask_nxt  = w_win_id[1] ? 2'b00 : (w_win_id[0] ? 2'b10 : 2'b01);
               w_rd_mask_nxt  = w_win_id[1] ? (w_win_id[0] ? 2'b10 : 2'b01) : 2'b00;
               w_grant_id_nxt = w_win_id;
            end
         end
         ST_BUSY: begin
            if (w_done) begin
               w_state_nxt    = ST_GAP;
               w_req_wr_nxt   = 1'b0;
               w_req_rd_nxt   = 1'b0;
               w_req_addr_nxt = '0;
               w_req_len_nxt  = '0;
               w_wr_mask_nxt  = 2'b00;
               w_rd_mask_nxt  = 2'b00;
            end
         end
         ST_GAP: begin
            // one dead cycle so the sequencer's edge detector sees the request low
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Output registers; GRANT_ID resets to 3 so round-robin starts its search at port 0.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_req_wr   <= 1'b0;
         r_req_rd   <= 1'b0;
         r_req_addr <= '0;
         r_req_len  <= '0;
         r_wr_mask  <= 2'b00;
         r_rd_mask  <= 2'b00;
         r_grant_id <= 2'd3;
      end else begin
         r_req_wr   <= w_req_wr_nxt;
         r_req_rd   <= w_req_rd_nxt;
         r_req_addr <= w_req_addr_nxt;
         r_req_len  <= w_req_len_nxt;
         r_wr_mask  <= w_wr_mask_nxt;
         r_rd_mask  <= w_rd_mask_nxt;
         r_grant_id <= w_grant_id_nxt;
      end
   end

   // Per-port registers: LOAD overrides everything; otherwise the granted port advances on done.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int p = 0; p < 4; p++) begin
            r_addr[p] <= '0;
            r_max[p]  <= '0;
            r_len[p]  <= LSIZE'(DEF_LENGTH);
         end
      end else begin
         for (int p = 0; p < 4; p++) begin
            if (bus.LOAD[p]) begin
               r_addr[p] <= bus.START_ADDR[p*ASIZE +: ASIZE];
               r_max[p]  <= bus.MAX_ADDR[p*ASIZE +: ASIZE];
               r_len[p]  <= bus.LENGTH[p*LSIZE +: LSIZE];
            end else if (w_done && (r_grant_id == 2'(p))) begin
               r_addr[p] <= w_adv_addr[p];
            end
         end
      end
   end

   assign bus.REQ_WR     = r_req_wr;
   assign bus.REQ_RD     = r_req_rd;
   assign bus.REQ_ADDR   = r_req_addr;
   assign bus.REQ_LENGTH = r_req_len;
   assign bus.WR_MASK    = r_wr_mask;
   assign bus.RD_MASK    = r_rd_mask;
   assign bus.GRANT_ID   = r_grant_id;

endmodule

// File: tb/tb_sdram_port_scheduler.sv
// Directed bench for sdram_port_scheduler: grant, wrap walk, priority, LOAD and reset corner cases.
// Inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
// Expected values are hand-computed per scenario.
module tb_sdram_port_scheduler;
   localparam int A = 22;
   localparam int L = 9;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   sdram_port_scheduler_if #(.ASIZE(A), .LSIZE(L)) bus ();

   sdram_port_scheduler #(.ASIZE(A), .LSIZE(L), .DEF_LENGTH(256)) dut (
      .CLK     (clk),
      .RESET_N (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one clock, land just after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic [A-1:0] st, input logic [A-1:0] mx,
                           input logic [L-1:0] len);
      bus.START_ADDR[p*A +: A] = st;
      bus.MAX_ADDR[p*A +: A]   = mx;
      bus.LENGTH[p*L +: L]     = len;
   endtask

   task automatic set_usedw(input int p, input logic [L-1:0] v);
      bus.USEDW[p*L +: L] = v;
   endtask

   // reset with every port ineligible and the sequencer busy
   task automatic do_reset();
      rst_n        = 1'b0;
      bus.LOAD     = 4'b0000;
      bus.WR_DONE  = 1'b0;
      bus.RD_DONE  = 1'b0;
      bus.SEQ_IDLE = 1'b0;
      bus.START_ADDR = '0;
      bus.MAX_ADDR   = '0;
      bus.LENGTH     = '0;
      set_usedw(0, 9'd0);
      set_usedw(1, 9'd0);
      set_usedw(2, 9'd300);
      set_usedw(3, 9'd300);
      #12;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      rst_n = 1'b0;
      #2;
      total++;
      if ({bus.REQ_WR, bus.REQ_RD, bus.WR_MASK, bus.RD_MASK, bus.GRANT_ID} !== 8'b0_0_00_00_11) begin
         bad++;
         $display("FAIL reset_ctrl got=%b want=00000011",
                  {bus.REQ_WR, bus.REQ_RD, bus.WR_MASK, bus.RD_MASK, bus.GRANT_ID});
      end
      total++;
      if (bus.REQ_ADDR !== 22'd0) begin
         bad++; $display("FAIL reset_addr got=%h want=0", bus.REQ_ADDR);
      end
      total++;
      if (bus.REQ_LENGTH !== 9'd0) begin
         bad++; $display("FAIL reset_len got=%0d want=0", bus.REQ_LENGTH);
      end
      rst_n = 1'b1;
      tick();
   endtask

   // first grant after a LOAD, then the 4-step walk with wrap; leaves port 0 busy at addr 0
   task automatic test_grant_and_wrap();
      logic [A-1:0] exp_addr [4];
      exp_addr[0] = 22'd256; exp_addr[1] = 22'd512; exp_addr[2] = 22'd768; exp_addr[3] = 22'd0;
      do_reset();
      set_port(0, 22'd0, 22'd1024, 9'd256);
      bus.LOAD = 4'b0001;
      tick();
      bus.LOAD = 4'b0000;
      set_usedw(0, 9'd256);
      bus.SEQ_IDLE = 1'b1;
      total++;
      if (bus.REQ_WR !== 1'b0) begin
         bad++; $display("FAIL grant_early got=%b want=0", bus.REQ_WR);
      end
      tick();
      total++;
      if ({bus.REQ_WR, bus.REQ_RD, bus.WR_MASK, bus.RD_MASK, bus.GRANT_ID} !== 8'b1_0_01_00_00) begin
         bad++;
         $display("FAIL grant_ctrl got=%b want=10010000",
                  {bus.REQ_WR, bus.REQ_RD, bus.WR_MASK, bus.RD_MASK, bus.GRANT_ID});
      end
      total++;
      if (bus.REQ_ADDR !== 22'd0 || bus.REQ_LENGTH !== 9'd256) begin
         bad++; $display("FAIL grant_burst got=%h/%0d want=0/256", bus.REQ_ADDR, bus.REQ_LENGTH);
      end
      for (int i = 0; i < 4; i++) begin
         bus.WR_DONE = 1'b1;
         tick();
         bus.WR_DONE = 1'b0;
         total++;
         if (bus.REQ_WR !== 1'b0 || bus.WR_MASK !== 2'b00) begin
            bad++; $display("FAIL wrap_gap1[%0d] got=%b/%b want=0/00", i, bus.REQ_WR, bus.WR_MASK);
         end
         tick();
         total++;
         if (bus.REQ_WR !== 1'b0) begin
            bad++; $display("FAIL wrap_gap2[%0d] got=%b want=0", i, bus.REQ_WR);
         end
         tick();
         total++;
         if (bus.REQ_WR !== 1'b1 || bus.REQ_ADDR !== exp_addr[i]) begin
            bad++;
            $display("FAIL wrap_addr[%0d] got=%b/%h want=1/%h", i, bus.REQ_WR, bus.REQ_ADDR, exp_addr[i]);
         end
      end
   endtask

   // continues from the port-0 burst at address 0
   task automatic test_wrong_done_ignored();
      bus.RD_DONE = 1'b1;
      tick();
      bus.RD_DONE = 1'b0;
      total++;
      if (bus.REQ_WR !== 1'b1 || bus.REQ_ADDR !== 22'd0) begin
         bad++; $display("FAIL rd_done_ignored got=%b/%h want=1/0", bus.REQ_WR, bus.REQ_ADDR);
      end
      bus.WR_DONE = 1'b1;
      tick();
      bus.WR_DONE = 1'b0;
      total++;
      if (bus.REQ_WR !== 1'b0) begin
         bad++; $display("FAIL wr_done_clear got=%b want=0", bus.REQ_WR);
      end
      tick();
      total++;
      if (bus.REQ_WR !== 1'b0) begin
         bad++; $display("FAIL wr_done_gap got=%b want=0", bus.REQ_WR);
      end
      tick();
      total++;
      if (bus.REQ_WR !== 1'b1 || bus.REQ_ADDR !== 22'd256) begin
         bad++; $display("FAIL after_rd_done_addr got=%b/%h want=1/100", bus.REQ_WR, bus.REQ_ADDR);
      end
   endtask

   // ports 0 and 2 continuously eligible
   task automatic test_priority();
      logic [1:0] exp_id [4];
`ifdef SCHED_ROUND_ROBIN_EN
      exp_id[0] = 2'd0; exp_id[1] = 2'd2; exp_id[2] = 2'd0; exp_id[3] = 2'd2;
`else
      exp_id[0] = 2'd0; exp_id[1] = 2'd0; exp_id[2] = 2'd0; exp_id[3] = 2'd0;
`endif
      do_reset();
      set_usedw(0, 9'd256);
      set_usedw(2, 9'd0);
      bus.SEQ_IDLE = 1'b1;
      for (int i = 0; i < 4; i++) begin
         logic [7:0] exp_ctrl;
         exp_ctrl = (exp_id[i] == 2'd0) ? 8'b1_0_01_00_00 : 8'b0_1_00_01_10;
         tick();
         total++;
         if ({bus.REQ_WR, bus.REQ_RD, bus.WR_MASK, bus.RD_MASK, bus.GRANT_ID} !== exp_ctrl) begin
            bad++;
            $display("FAIL prio_grant[%0d] got=%b want=%b", i,
                     {bus.REQ_WR, bus.REQ_RD, bus.WR_MASK, bus.RD_MASK, bus.GRANT_ID}, exp_ctrl);
         end
         if (exp_id[i] == 2'd0) bus.WR_DONE = 1'b1;
         else                   bus.RD_DONE = 1'b1;
         tick();
         bus.WR_DONE = 1'b0;
         bus.RD_DONE = 1'b0;
         tick();
      end
   endtask

   // LOAD on the running read port, then reset while that port is busy
   task automatic test_load_and_reset_mid_burst();
      do_reset();
      set_usedw(2, 9'd0);
      bus.SEQ_IDLE = 1'b1;
      tick();
      total++;
      if ({bus.REQ_WR, bus.REQ_RD, bus.WR_MASK, bus.RD_MASK, bus.GRANT_ID} !== 8'b0_1_00_01_10) begin
         bad++;
         $display("FAIL rd_grant got=%b want=01000110",
                  {bus.REQ_WR, bus.REQ_RD, bus.WR_MASK, bus.RD_MASK, bus.GRANT_ID});
      end
      set_port(2, 22'h100000, 22'h200000, 9'd128);
      bus.LOAD = 4'b0100;
      tick();
      total++;
      if (bus.REQ_RD !== 1'b1 || bus.REQ_ADDR !== 22'd0 || bus.REQ_LENGTH !== 9'd256) begin
         bad++;
         $display("FAIL load_frozen got=%b/%h/%0d want=1/0/256", bus.REQ_RD, bus.REQ_ADDR, bus.REQ_LENGTH);
      end
      bus.RD_DONE = 1'b1;
      tick();
      bus.RD_DONE = 1'b0;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (bus.REQ_RD !== 1'b0) begin
            bad++; $display("FAIL load_blocks[%0d] got=%b want=0", i, bus.REQ_RD);
         end
         tick();
      end
      bus.LOAD = 4'b0000;
      tick();
      total++;
      if (bus.REQ_RD !== 1'b1 || bus.REQ_ADDR !== 22'h100000 || bus.REQ_LENGTH !== 9'd128) begin
         bad++;
         $display("FAIL load_regrant got=%b/%h/%0d want=1/100000/128", bus.REQ_RD, bus.REQ_ADDR, bus.REQ_LENGTH);
      end
      rst_n = 1'b0;
      #2;
      total++;
      if ({bus.REQ_WR, bus.REQ_RD, bus.WR_MASK, bus.RD_MASK, bus.GRANT_ID} !== 8'b0_0_00_00_11
          || bus.REQ_ADDR !== 22'd0) begin
         bad++;
         $display("FAIL async_reset got=%b/%h want=00000011/0",
                  {bus.REQ_WR, bus.REQ_RD, bus.WR_MASK, bus.RD_MASK, bus.GRANT_ID}, bus.REQ_ADDR);
      end
      rst_n = 1'b1;
      tick();
      total++;
      if (bus.REQ_RD !== 1'b1 || bus.REQ_ADDR !== 22'd0 || bus.REQ_LENGTH !== 9'd256) begin
         bad++;
         $display("FAIL reset_port_regs got=%b/%h/%0d want=1/0/256", bus.REQ_RD, bus.REQ_ADDR, bus.REQ_LENGTH);
      end
   endtask

   // done pulses outside BUSY must not move any address
   task automatic test_done_idle();
      do_reset();
      set_port(0, 22'h40, 22'h1000, 9'd256);
      bus.LOAD = 4'b0001;
      tick();
      bus.LOAD = 4'b0000;
      set_usedw(0, 9'd256);
      bus.WR_DONE = 1'b1;
      bus.RD_DONE = 1'b1;
      tick();
      tick();
      bus.WR_DONE = 1'b0;
      bus.RD_DONE = 1'b0;
      total++;
      if (bus.REQ_WR !== 1'b0) begin
         bad++; $display("FAIL idle_no_grant got=%b want=0", bus.REQ_WR);
      end
      bus.SEQ_IDLE = 1'b1;
      tick();
      total++;
      if (bus.REQ_WR !== 1'b1 || bus.REQ_ADDR !== 22'h40) begin
         bad++; $display("FAIL idle_done_addr got=%b/%h want=1/40", bus.REQ_WR, bus.REQ_ADDR);
      end
   endtask

   // len 0 parks a port; USEDW one short of len is not enough
   task automatic test_len_boundary();
      do_reset();
      set_port(0, 22'd0, 22'd1024, 9'd0);
      set_port(2, 22'd0, 22'd1024, 9'd0);
      bus.LOAD = 4'b0101;
      tick();
      bus.LOAD = 4'b0000;
      set_usedw(2, 9'd0);
      bus.SEQ_IDLE = 1'b1;
      tick();
      tick();
      total++;
      if (bus.REQ_WR !== 1'b0 || bus.REQ_RD !== 1'b0) begin
         bad++; $display("FAIL len_zero got=%b%b want=00", bus.REQ_WR, bus.REQ_RD);
      end
      set_port(0, 22'd0, 22'd1024, 9'd256);
      bus.LOAD = 4'b0001;
      set_usedw(0, 9'd255);
      tick();
      bus.LOAD = 4'b0000;
      tick();
      tick();
      total++;
      if (bus.REQ_WR !== 1'b0) begin
         bad++; $display("FAIL usedw_short got=%b want=0", bus.REQ_WR);
      end
      set_usedw(0, 9'd256);
      tick();
      total++;
      if (bus.REQ_WR !== 1'b1 || bus.WR_MASK !== 2'b01) begin
         bad++; $display("FAIL usedw_exact got=%b/%b want=1/01", bus.REQ_WR, bus.WR_MASK);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.LOAD = 4'b0000;
      bus.WR_DONE = 1'b0;
      bus.RD_DONE = 1'b0;
      bus.SEQ_IDLE = 1'b0;
      bus.USEDW = '0;
      bus.START_ADDR = '0;
      bus.MAX_ADDR = '0;
      bus.LENGTH = '0;
      test_reset();
      test_grant_and_wrap();
      test_wrong_done_ignored();
      test_priority();
      test_load_and_reset_mid_burst();
      test_done_idle();
      test_len_boundary();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
